// File: rtl/pong_pkg.sv
// Shared pong definitions: game phase encodings and default game tuning.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam int WIN_SCORE_DEF   = 7;
  localparam int DELAY_TICKS_DEF = 120;

endpackage

// File: rtl/pong_edge_det.sv
// One-bit registered rising-edge detector; rise pulses one cycle after the input goes high.
module pong_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;
  logic armed;

  // armed stays low for the first cycle out of reset, so a level held through reset is
  // absorbed into prev without firing; it must drop and rise again to produce an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      rise  <= 1'b0;
    end else begin
      armed <= 1'b1;
      prev  <= level;
      rise  <= level & ~prev & armed;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: scores, rally count and NEWGAME/PLAY/NEWBALL/OVER phases.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int DELAY_TICKS = DELAY_TICKS_DEF,
  parameter int RALLY_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               refresh_tick,
  input  logic               btn_start,
  input  logic               hit_a,
  input  logic               hit_b,
  input  logic               miss_a,
  input  logic               miss_b,
  output logic               gra_still,
  output logic [3:0]         score_a,
  output logic [3:0]         score_b,
  output logic [RALLY_W-1:0] rally,
  output logic               game_over,
  output logic               winner,
  output logic [1:0]         state_o
);

  localparam int DT = (DELAY_TICKS == 0) ? 1 : DELAY_TICKS;
  localparam int TW = $clog2(DT + 1);
  localparam logic [TW-1:0] TLOAD = TW'(DT);
  localparam logic [3:0]    WIN   = 4'(WIN_SCORE);

  logic btn_re, hit_a_re, hit_b_re, miss_a_re, miss_b_re;

  pong_edge_det u_ed_btn  (.clk(clk), .reset(reset), .level(btn_start), .rise(btn_re));
  pong_edge_det u_ed_hita (.clk(clk), .reset(reset), .level(hit_a),     .rise(hit_a_re));
  pong_edge_det u_ed_hitb (.clk(clk), .reset(reset), .level(hit_b),     .rise(hit_b_re));
  pong_edge_det u_ed_misa (.clk(clk), .reset(reset), .level(miss_a),    .rise(miss_a_re));
  pong_edge_det u_ed_misb (.clk(clk), .reset(reset), .level(miss_b),    .rise(miss_b_re));

  state_t             state, state_n;
  logic [TW-1:0]      timer, timer_n;
  logic [3:0]         score_a_n, score_b_n;
  logic [RALLY_W-1:0] rally_n;
  logic               winner_n;

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    score_a_n = score_a;
    score_b_n = score_b;
    rally_n   = rally;
    winner_n  = winner;
    case (state)
      ST_NEWGAME: begin
        if (btn_re) begin
          score_a_n = 4'd0;
          score_b_n = 4'd0;
          rally_n   = '0;
          winner_n  = 1'b0;
          state_n   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Misses take priority over hits, and miss_a over miss_b.
        if (miss_a_re) begin
          score_b_n = score_b + 4'd1;
          rally_n   = '0;
          timer_n   = TLOAD;
          if (score_b_n == WIN) begin
            winner_n = 1'b1;
            state_n  = ST_OVER;
          end else begin
            state_n  = ST_NEWBALL;
          end
        end else if (miss_b_re) begin
          score_a_n = score_a + 4'd1;
          rally_n   = '0;
          timer_n   = TLOAD;
          if (score_a_n == WIN) begin
            winner_n = 1'b0;
            state_n  = ST_OVER;
          end else begin
            state_n  = ST_NEWBALL;
          end
        end else if ((hit_a_re || hit_b_re) && (rally != '1)) begin
          rally_n = rally + RALLY_W'(1);
        end
      end
      ST_NEWBALL, ST_OVER: begin
        if (refresh_tick) begin
          if (timer <= TW'(1)) begin
            timer_n = '0;
            state_n = (state == ST_NEWBALL) ? ST_PLAY : ST_NEWGAME;
          end else begin
            timer_n = timer - TW'(1);
          end
        end
      end
      default: state_n = ST_NEWGAME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_NEWGAME;
      timer     <= '0;
      score_a   <= 4'd0;
      score_b   <= 4'd0;
      rally     <= '0;
      winner    <= 1'b0;
      gra_still <= 1'b1;
      game_over <= 1'b0;
      state_o   <= 2'd0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      score_a   <= score_a_n;
      score_b   <= score_b_n;
      rally     <= rally_n;
      winner    <= winner_n;
      gra_still <= (state_n != ST_PLAY);
      game_over <= (state_n == ST_OVER);
      state_o   <= state_n;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with WIN_SCORE=3, DELAY_TICKS=3.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refresh_tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       hit_a = 1'b0, hit_b = 1'b0, miss_a = 1'b0, miss_b = 1'b0;
  logic       gra_still, game_over, winner;
  logic [3:0] score_a, score_b;
  logic [7:0] rally;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  pong_game_ctrl #(.WIN_SCORE(3), .DELAY_TICKS(3), .RALLY_W(8)) dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .btn_start(btn_start),
    .hit_a(hit_a), .hit_b(hit_b), .miss_a(miss_a), .miss_b(miss_b),
    .gra_still(gra_still), .score_a(score_a), .score_b(score_b), .rally(rally),
    .game_over(game_over), .winner(winner), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // which: 0 btn, 1 hit_a, 2 hit_b, 3 miss_a, 4 miss_b
  task automatic pulse(input int which);
    case (which)
      0: btn_start = 1'b1;
      1: hit_a = 1'b1;
      2: hit_b = 1'b1;
      3: miss_a = 1'b1;
      default: miss_b = 1'b1;
    endcase
    cyc(1);
    {btn_start, hit_a, hit_b, miss_a, miss_b} = '0;
    cyc(3);
  endtask

  task automatic tick();
    refresh_tick = 1'b1;
    cyc(1);
    refresh_tick = 1'b0;
  endtask

  task automatic serve();
    for (int i = 0; i < 3; i++) begin
      cyc(2);
      tick();
    end
    cyc(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " state"}, state_o, 0);
    check({tag, " still"}, gra_still, 1);
    check({tag, " score_a"}, score_a, 0);
    check({tag, " score_b"}, score_b, 0);
    check({tag, " rally"}, rally, 0);
    check({tag, " over"}, game_over, 0);
    check({tag, " winner"}, winner, 0);
  endtask

  initial begin
    cyc(3);
    check_reset_vals("reset");
    reset = 1'b0;
    cyc(3);

    // Start: held button gives a single PLAY entry, still drops 2 cycles after edge
    btn_start = 1'b1;
    cyc(1);
    check("start still n+1", gra_still, 1);
    cyc(1);
    check("start still n+2", gra_still, 0);
    check("start state", state_o, 1);
    cyc(8);
    btn_start = 1'b0;
    cyc(2);
    check("start hold state", state_o, 1);
    check("start scores", {score_a, score_b}, 0);

    // Rally: long levels count once each, then saturation
    hit_a = 1'b1; cyc(50); hit_a = 1'b0;
    hit_b = 1'b1; cyc(50); hit_b = 1'b0;
    cyc(3);
    check("rally two", rally, 2);
    for (int i = 0; i < 300; i++) begin
      hit_a = 1'b1; cyc(1); hit_a = 1'b0; cyc(1);
    end
    cyc(2);
    check("rally sat", rally, 255);

    // Serve delay
    pulse(3);
    check("miss_a score_b", score_b, 1);
    check("miss_a rally", rally, 0);
    check("miss_a state", state_o, 2);
    check("miss_a still", gra_still, 1);
    pulse(3);
    check("nb ignore score_b", score_b, 1);
    check("nb ignore state", state_o, 2);
    cyc(2); tick(); cyc(2); tick();
    check("nb after 2 ticks", state_o, 2);
    cyc(2); tick();
    check("nb after 3 ticks", state_o, 1);
    check("nb resume still", gra_still, 0);
    cyc(2);

    // Simultaneous misses: miss_a wins
    miss_a = 1'b1; miss_b = 1'b1; cyc(1); miss_a = 1'b0; miss_b = 1'b0; cyc(3);
    check("both miss score_b", score_b, 2);
    check("both miss score_a", score_a, 0);
    serve();
    check("serve2 state", state_o, 1);
    pulse(1);
    check("pre hit rally", rally, 1);
    // Hit and miss together: point scored, no rally increment
    hit_a = 1'b1; miss_b = 1'b1; cyc(1); hit_a = 1'b0; miss_b = 1'b0; cyc(3);
    check("hit+miss score_a", score_a, 1);
    check("hit+miss rally", rally, 0);
    check("hit+miss state", state_o, 2);
    serve();

    // Win for A
    pulse(4);
    check("a2 score", score_a, 2);
    serve();
    pulse(4);
    check("win state", state_o, 3);
    check("win over", game_over, 1);
    check("win winner", winner, 0);
    check("win score_a", score_a, 3);
    check("win still", gra_still, 1);
    pulse(0);
    check("over ignores btn", state_o, 3);
    serve();
    check("newgame state", state_o, 0);
    check("newgame over", game_over, 0);
    check("newgame score_a held", score_a, 3);
    check("newgame score_b held", score_b, 2);
    pulse(0);
    check("restart state", state_o, 1);
    check("restart scores", {score_a, score_b}, 0);

    // Reset in NEWBALL with button held
    pulse(3);
    check("pre reset state", state_o, 2);
    btn_start = 1'b1;
    cyc(2);
    #2 reset = 1'b1;
    #1 check_reset_vals("midreset");
    cyc(2);
    reset = 1'b0;
    cyc(10);
    check("held btn no start", state_o, 0);
    btn_start = 1'b0;
    cyc(3);
    btn_start = 1'b1;
    cyc(2);
    check("repress start", state_o, 1);
    btn_start = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
